// File: rtl/ram_bank_wb_pkg.sv
// ---------------------------------------------------------------------------
// ram_bank_wb_pkg
// Purpose : shared defaults for the write-back RAM bank and its helpers.
// Contents: default address width, word width and bank depth, plus a word
//           type at the default width for code that works on whole words.
// ---------------------------------------------------------------------------
package ram_bank_wb_pkg;

  localparam int DEF_ADDR_BIT   = 3;
  localparam int DEF_DATA_BIT   = 16;
  localparam int DEF_MEM_HEIGHT = 8;

  typedef logic [DEF_DATA_BIT-1:0] word_t;

endpackage

// File: rtl/ram_bank_wb_mux21.sv
// ---------------------------------------------------------------------------
// mux21
// Purpose : generic 2:1 select, used in front of the RAM bank write port so
//           the datapath can pick between an external operand and a result.
// Ports   : a    - input chosen when sel = 0
//           b    - input chosen when sel = 1
//           sel  - select
//           y    - selected value (combinational)
// ---------------------------------------------------------------------------
module mux21
  import ram_bank_wb_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_BIT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // Pure combinational select; no state, so a registered value may be fed
  // back into b without creating a loop.
  always_comb begin
    y = a;
    if (sel) begin
      y = b;
    end
  end

endmodule

// File: rtl/ram_bank_wb.sv
// ---------------------------------------------------------------------------
// ram_bank_wb
// Purpose : register-file RAM bank with a synchronous write port, a
//           registered read port and a 2:1 write-data select, so a
//           read -> compute -> write-back loop can run every cycle.
// Ports   : clk     - clock, all state updates on the rising edge
//           rst     - asynchronous active-high reset (clears memory and d_r)
//           en      - bank enable, gates both ports
//           we, re  - write / read enables
//           sel     - write-data select: 0 = d_in, 1 = fb
//           d_in    - external write operand
//           fb      - fed-back write operand
//           addr_w  - write address
//           addr_r  - read address
//           d_w     - selected write data (combinational)
//           d_r     - registered read data
// ---------------------------------------------------------------------------
module ram_bank_wb
  import ram_bank_wb_pkg::*;
#(
  parameter int ADDR_BIT   = DEF_ADDR_BIT,
  parameter int DATA_BIT   = DEF_DATA_BIT,
  parameter int MEM_HEIGHT = DEF_MEM_HEIGHT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic                re,
  input  logic                sel,
  input  logic [DATA_BIT-1:0] d_in,
  input  logic [DATA_BIT-1:0] fb,
  input  logic [ADDR_BIT-1:0] addr_w,
  input  logic [ADDR_BIT-1:0] addr_r,
  output logic [DATA_BIT-1:0] d_w,
  output logic [DATA_BIT-1:0] d_r
);

  // Depth held one bit wider than the address so a full 2^ADDR_BIT bank
  // still compares correctly.
  localparam logic [ADDR_BIT:0] HEIGHT = (ADDR_BIT + 1)'(MEM_HEIGHT);

  logic [DATA_BIT-1:0] mem [MEM_HEIGHT];
  logic                w_ok;
  logic                r_ok;

  mux21 #(
    .WIDTH (DATA_BIT)
  ) u_wsel (
    .a   (d_in),
    .b   (fb),
    .sel (sel),
    .y   (d_w)
  );

  // Address range checks; out-of-range writes are dropped and
  // out-of-range reads return zero.
  always_comb begin
    w_ok = ({1'b0, addr_w} < HEIGHT);
    r_ok = ({1'b0, addr_r} < HEIGHT);
  end

  // Memory array: cleared by reset, written with the selected data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_HEIGHT; i++) begin
        mem[i] <= '0;
      end
    end else if (en && we && w_ok) begin
      mem[addr_w] <= d_w;
    end
  end

  // Read register: samples the pre-edge memory contents, which gives
  // read-first behaviour when reading and writing the same address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r <= '0;
    end else if (en && re) begin
      if (r_ok) begin
        d_r <= mem[addr_r];
      end else begin
        d_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_bank_wb.sv
// ---------------------------------------------------------------------------
// tb_ram_bank_wb
// Purpose : self-checking bench for ram_bank_wb. Drives a directed vector
//           table plus hand-written sequences for reset, the feedback loop,
//           out-of-range accesses (on a shallower second instance) and the
//           combinational write-data select.
// ---------------------------------------------------------------------------
module tb_ram_bank_wb;
  import ram_bank_wb_pkg::*;

  typedef struct {
    logic        en;
    logic        we;
    logic        re;
    logic        sel;
    word_t       d_in;
    word_t       fb;
    logic [2:0]  addr_w;
    logic [2:0]  addr_r;
    word_t       exp_d_r;
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, we, re, sel;
  word_t      d_in, fb_tb, fb;
  logic [2:0] addr_w, addr_r;
  word_t      d_w, d_r;
  word_t      d_w_s, d_r_s;
  logic       loop_mode;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  // Feedback operand is either a plain stimulus value or twice the
  // registered read data, closing the write-back loop.
  assign fb = loop_mode ? {d_r[14:0], 1'b0} : fb_tb;

  always #5 clk = ~clk;

  ram_bank_wb u_dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .we     (we),
    .re     (re),
    .sel    (sel),
    .d_in   (d_in),
    .fb     (fb),
    .addr_w (addr_w),
    .addr_r (addr_r),
    .d_w    (d_w),
    .d_r    (d_r)
  );

  // Shallower bank so addresses 6 and 7 are out of range.
  ram_bank_wb #(
    .ADDR_BIT   (3),
    .DATA_BIT   (16),
    .MEM_HEIGHT (6)
  ) u_small (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .we     (we),
    .re     (re),
    .sel    (sel),
    .d_in   (d_in),
    .fb     (fb),
    .addr_w (addr_w),
    .addr_r (addr_r),
    .d_w    (d_w_s),
    .d_r    (d_r_s)
  );

  function automatic vec_t mk(input logic e, input logic w, input logic r,
                              input logic s, input word_t di, input word_t f,
                              input logic [2:0] aw, input logic [2:0] ar,
                              input word_t exp, input string nm);
    vec_t v;
    v.en = e; v.we = w; v.re = r; v.sel = s;
    v.d_in = di; v.fb = f; v.addr_w = aw; v.addr_r = ar;
    v.exp_d_r = exp; v.name = nm;
    return v;
  endfunction

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one vector on the falling edge, lets one rising edge pass, then
  // checks the main instance's registered read data.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    en = v.en; we = v.we; re = v.re; sel = v.sel;
    d_in = v.d_in; fb_tb = v.fb; addr_w = v.addr_w; addr_r = v.addr_r;
    @(posedge clk);
    #1;
    checkOutput(v.name, d_r, v.exp_d_r);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; re = 1'b0; sel = 1'b0;
    d_in = '0; fb_tb = '0; addr_w = '0; addr_r = '0; loop_mode = 1'b0;

    // ---- reset state and reset clearing ----
    #2;
    checkOutput("reset_d_r", d_r, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(mk(1, 1, 0, 0, 16'hBEEF, 0, 3'(i), 0, 16'h0000, "fill_beef"));
    end
    applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 3'd4, 16'hBEEF, "read_beef"));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_d_r", d_r, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 3'(i), 16'h0000, "rst_mem_clear"));
    end

    // ---- table: external writes, readback, collision, enable gating ----
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1, 1, 0, 0, 16'(i + 1), 0, 3'(i), 0, 16'h0000, "ext_write_hold"));
    end
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 3'(i), 16'(i + 1), "ext_readback"));
    end
    vecs.push_back(mk(1, 1, 0, 0, 16'd5,  0, 3'd3, 0,    16'd8,  "coll_setup"));
    vecs.push_back(mk(1, 1, 1, 0, 16'd10, 0, 3'd3, 3'd3, 16'd5,  "coll_read_first"));
    vecs.push_back(mk(1, 0, 1, 0, 0,      0, 0,    3'd3, 16'd10, "coll_new_value"));
    vecs.push_back(mk(0, 1, 1, 0, 16'd7,  0, 3'd1, 3'd1, 16'd10, "en0_hold"));
    vecs.push_back(mk(1, 0, 1, 0, 0,      0, 0,    3'd1, 16'd2,  "en0_mem_unchanged"));
    vecs.push_back(mk(1, 0, 0, 0, 0,      0, 0,    3'd3, 16'd2,  "re0_hold"));
    vecs.push_back(mk(1, 1, 1, 1, 16'd9,  16'h0044, 3'd6, 3'd6, 16'd7, "sel1_write_fb"));
    vecs.push_back(mk(1, 0, 1, 0, 0,      0, 0,    3'd6, 16'h0044, "sel1_readback"));
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
    end

    // ---- feedback loop on address 2 ----
    applyStimulus(mk(1, 1, 0, 0, 16'd0, 0, 3'd2, 3'd2, 16'h0044, "fb_clear"));
    applyStimulus(mk(1, 1, 1, 0, 16'd3, 0, 3'd2, 3'd2, 16'd0, "fb_p1_e1"));
    applyStimulus(mk(1, 1, 1, 0, 16'd3, 0, 3'd2, 3'd2, 16'd3, "fb_p1_e2"));
    loop_mode = 1'b1;
    begin
      word_t fb_exp[6];
      fb_exp = '{16'd3, 16'd6, 16'd6, 16'd12, 16'd12, 16'd24};
      for (int i = 0; i < 6; i++) begin
        applyStimulus(mk(1, 1, 1, 1, 16'd3, 0, 3'd2, 3'd2, fb_exp[i], "fb_p2"));
      end
    end
    loop_mode = 1'b0;

    // ---- out-of-range access on the 6-word instance ----
    applyStimulus(mk(1, 1, 0, 0, 16'h0055, 0, 3'd5, 0, 16'd24, "oor_w5"));
    applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 3'd5, 16'h0055, "oor_r5_main"));
    checkOutput("oor_r5_small", d_r_s, 16'h0055);
    applyStimulus(mk(1, 1, 0, 0, 16'h0066, 0, 3'd6, 0, 16'h0055, "oor_w6"));
    applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 3'd6, 16'h0066, "oor_r6_main"));
    checkOutput("oor_r6_small_zero", d_r_s, 16'h0000);
    applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 3'd5, 16'h0055, "oor_r5_again"));
    checkOutput("oor_r5_small_kept", d_r_s, 16'h0055);

    // ---- combinational write-data select, within one cycle ----
    @(negedge clk);
    en = 1'b0; we = 1'b0; re = 1'b0;
    d_in = 16'h1111; fb_tb = 16'h2222; sel = 1'b0;
    #1;
    checkOutput("mux_sel0", d_w, 16'h1111);
    sel = 1'b1;
    #1;
    checkOutput("mux_sel1", d_w, 16'h2222);
    sel = 1'b0;
    #1;
    checkOutput("mux_sel0_again", d_w, 16'h1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_bank_wb.md
# ram_bank_wb

Parameterised register-file RAM bank with a 2:1 write-data select in front of its write port. It has a synchronous write port and a registered read port. It lets a datapath write either an external operand or a fed-back computed result into the same bank. It sits between a compute unit and its local storage, so that read → compute → write-back loops can run every cycle.

## Interface
Parameters:
- ADDR_BIT, 3, width of the read and write addresses
- DATA_BIT, 16, word width
- MEM_HEIGHT, 8, number of words (≤ 2^ADDR_BIT)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  bank enable; gates both read and write
- we  input  1  write enable
- re  input  1  read enable
- sel  input  1  write-data select: 0 = d_in, 1 = fb
- d_in  input  DATA_BIT  external write operand
- fb  input  DATA_BIT  fed-back write operand (e.g. a computed result derived from d_r)
- addr_w  input  ADDR_BIT  write address
- addr_r  input  ADDR_BIT  read address
- d_w  output  DATA_BIT  selected write data, combinational
- d_r  output  DATA_BIT  registered read data

## Operation
- Write-data select: d_w = sel ? fb : d_in. Purely combinational, with no state.
- Write: at a rising edge where en & we and addr_w < MEM_HEIGHT, mem[addr_w] ← d_w.
- Read: at a rising edge where en & re:
  - d_r ← mem[addr_r] if addr_r < MEM_HEIGHT;
  - d_r ← 0 otherwise.
- When en & re is false, d_r holds its value.
- Out-of-range writes (addr_w ≥ MEM_HEIGHT) are dropped. No memory word changes.
- en = 0 blocks both ports regardless of we and re.
- Read and write are independent and may target different addresses in the same cycle.

## Timing
- Reset (asynchronous, takes effect immediately on rst = 1):
  - all MEM_HEIGHT words clear to 0;
  - d_r clears to 0.
- While rst = 1, writes and reads are ignored.
- The first update after rst deasserts happens at the next rising edge.
- Write latency: the written word is visible to a read issued at the following edge.
- Read latency: 1 cycle. addr_r is sampled at edge N and the data appears on d_r after edge N.
- Read and write to the same address in the same edge: read-first. d_r receives the old content and the memory takes d_w.
- d_w responds combinationally to sel, d_in and fb.
  - Feeding fb from d_r creates no combinational loop, because d_r is registered.
- The block needs no handshake; every enabled access completes in its cycle.

## Structure
- Shared package: default ADDR_BIT/DATA_BIT/MEM_HEIGHT constants, plus a word typedef of width DATA_BIT.
- One sub-module, mux21: 2:1 select with inputs a, b, sel and output y.
  - Parameterised by width.
  - Instantiated in front of the write port.
- Memory array, write logic and read register live in the top block.

## Test plan
- Reset clear:
  - Stimulus: write 0xBEEF to every address, assert rst mid-cycle, deassert it, then read addresses 0–7.
  - Required: d_r = 0 immediately on rst, and every address reads back 0.
- External write and readback:
  - Stimulus: sel = 0, d_in = addr + 1, write addresses 0–7 one per cycle, then read 0–7.
  - Required: d_r = 1..8, each appearing one cycle after its address.
- Feedback loop:
  - Stimulus: en = we = re = 1, addr_w = addr_r = 2, fb = 2·d_r.
  - Phase 1: sel = 0 with d_in = 3 for 2 edges. Required: d_r = 0, then 3.
  - Phase 2: sel = 1. Required: d_r = 3, 6, 6, 12, 12, 24 on successive edges (read-first).
- Read/write collision:
  - Stimulus: mem[3] = 5, then in one cycle write 10 to address 3 while reading address 3, then read address 3 again.
  - Required: d_r = 5, then 10.
- Enable gating:
  - Stimulus: en = 0 with we = re = 1 and d_in = 7 to address 1.
  - Required: mem[1] unchanged and d_r holds its value.
  - Stimulus: re = 0 alone. Required: d_r holds.
- Mux select:
  - Stimulus: toggle sel with d_in = 0x1111 and fb = 0x2222.
  - Required: d_w follows combinationally in the same cycle, with no clock edge needed.
